// File: rtl/vga_draw_pkg.sv
// Shared screen geometry, field widths and encodings for the VGA drawing engines.
package vga_draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned XW       = 8;
    localparam int unsigned YW       = 7;
    localparam int unsigned CW       = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDraw   = 2'd1,
        StFinish = 2'd2
    } draw_state_e;

    localparam logic TGT_0 = 1'b0;
    localparam logic TGT_1 = 1'b1;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major column/row scan counter over a w x h rectangle with a last-pixel flag.
module rect_scan_counter
    import vga_draw_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    output logic [XW-1:0] i,
    output logic [YW-1:0] j,
    output logic          last
);

    logic [XW-1:0] i_q, i_d;
    logic [YW-1:0] j_q, j_d;
    logic          col_end;
    logic          row_end;

    assign col_end = (i_q == w - XW'(1));
    assign row_end = (j_q == h - YW'(1));

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (load) begin
            i_d = '0;
            j_d = '0;
        end else if (en) begin
            if (col_end) begin
                i_d = '0;
                j_d = row_end ? '0 : j_q + YW'(1);
            end else begin
                i_d = i_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign i    = i_q;
    assign j    = j_q;
    assign last = col_end && row_end;

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: one clipped pixel write per clock, row-major, to either adapter.
module vga_rect_filler
    import vga_draw_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          sel,
    input  logic [XW-1:0] x_in,
    input  logic [YW-1:0] y_in,
    input  logic [XW-1:0] w_in,
    input  logic [YW-1:0] h_in,
    input  logic [CW-1:0] colour_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot_0,
    output logic          plot_1,
    output logic          busy,
    output logic          done
);

    draw_state_e   state_q, state_d;

    logic [XW-1:0] x0_q, w_q;
    logic [YW-1:0] y0_q, h_q;
    logic [CW-1:0] fill_q;
    logic          sel_q;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] colour_q;
    logic          plot_0_q, plot_1_q, busy_q, done_q;

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          last;
    logic          load;
    logic [XW:0]   x_sum;
    logic [YW:0]   y_sum;
    logic          pixel_ok;

    assign load = (state_q == StIdle) && start;

    rect_scan_counter u_scan (
        .clk  (CLOCK_50),
        .rst  (reset),
        .load (load),
        .en   (state_q == StDraw),
        .w    (w_q),
        .h    (h_q),
        .i    (col),
        .j    (row),
        .last (last)
    );

    // One extra bit so a sum past the coordinate range is clipped rather than wrapped.
    assign x_sum    = {1'b0, x0_q} + {1'b0, col};
    assign y_sum    = {1'b0, y0_q} + {1'b0, row};
    assign pixel_ok = (32'(x_sum) < SCREEN_W) && (32'(y_sum) < SCREEN_H);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (w_in == '0 || h_in == '0) ? StFinish : StDraw;
                end
            end
            StDraw: begin
                if (last || abort) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            fill_q  <= '0;
            sel_q   <= TGT_0;
        end else begin
            state_q <= state_d;
            if (load) begin
                x0_q   <= x_in;
                y0_q   <= y_in;
                w_q    <= w_in;
                h_q    <= h_in;
                fill_q <= colour_in;
                sel_q  <= sel;
            end
        end
    end

    // Status and pixel outputs trail the state by one cycle so done follows the last pixel.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_0_q <= 1'b0;
            plot_1_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_q != StIdle);
            done_q <= (state_q == StFinish);
            if (state_q == StDraw) begin
                x_q      <= x_sum[XW-1:0];
                y_q      <= y_sum[YW-1:0];
                colour_q <= fill_q;
                plot_0_q <= pixel_ok && (sel_q == TGT_0);
                plot_1_q <= pixel_ok && (sel_q == TGT_1);
            end else begin
                plot_0_q <= 1'b0;
                plot_1_q <= 1'b0;
            end
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot_0 = plot_0_q;
    assign plot_1 = plot_1_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
